slave_fifo_ctrl: RTL
====================

SLAVE_FIFO_CTRL -- requirements
Module: slave_fifo_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1, is the number of clocks of data/OE settle time before a shift strobe.
REQ-002 Parameter PULSE_CYC, default 2, is the width in clocks of each SI or SOB strobe.
REQ-003 Parameter RECOV_CYC, default 2, is the number of clocks of recovery after a strobe before the FIFO flags are sampled again.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- fifo_slave_dor  in  1  data-output-ready of the host->slave FIFO pair.
- fifo_host_dir  in  1  data-input-ready of the slave->host FIFO pair.
- sd_in  in  8  slave data bus, read path.
- sd_out  out  8  slave data bus, write path.
- sd_oe  out  1  drive enable for sd_out.
- slave_fifo_wnr  out  1  level-shifter direction; 1 = drive toward FIFO.
- slave_fifo_oeb  out  1  active-low output enable of the host->slave FIFO.
- slave_fifo_sob  out  1  active-low shift-out strobe.
- slave_fifo_si  out  1  active-high shift-in strobe.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block accepts tx_data.
- busy  out  1  FSM is not in IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, RD_OE, RD_SO, WR_SET, WR_SI and RECOV.
REQ-006 In IDLE: oeb=1, sob=1, si=0, sd_oe=0, wnr=0.
REQ-007 A read is eligible when fifo_slave_dor=1 and the rx slot is empty, or is emptied in the same cycle (rx_valid & rx_ready).
REQ-008 A write is eligible when fifo_host_dir=1 and tx_valid=1; tx_ready SHALL be 1 only in an IDLE cycle that grants the write, and the byte is latched on that edge.
REQ-009 When both are eligible, priority SHALL alternate, starting with read after reset; a lone eligible request always wins.
REQ-010 Read path:
- RD_OE: oeb=0, wnr=0, for SETTLE_CYC clocks.
- sd_in is captured into rx_data at the last RD_OE edge; rx_valid=1 on the next cycle.
- RD_SO: oeb=0, sob=0, for PULSE_CYC clocks.
- Then RECOV.
REQ-011 Write path:
- WR_SET: wnr=1, sd_oe=1, sd_out=latched byte, for SETTLE_CYC clocks.
- WR_SI: si=1, data held, for PULSE_CYC clocks.
- Then RECOV with si=0 and data still driven.
REQ-012 RECOV SHALL last RECOV_CYC clocks, with oeb=1 and sob=1, then return to IDLE; sd_oe and wnr drop on entry to IDLE.
REQ-013 wnr SHALL change only in cycles where sd_oe=0 and oeb=1; a bus contention cycle is a failure.
REQ-014 rx_data/rx_valid SHALL hold until rx_valid & rx_ready, then rx_valid clears unless a new capture occurs the same edge.
REQ-015 Flag deassertion during RD_OE/RD_SO/WR_SET/WR_SI SHALL NOT abort the transfer; flags are sampled only in IDLE.
REQ-016 All phase counters SHALL be ceil(log2(max param + 1)) bits wide; parameter values below 1 are illegal.

Reset
REQ-017 On RESET, at the next CLK edge: FSM=IDLE, counters=0, rx_valid=0, rx_data=0, sd_out=0, sd_oe=0, wnr=0, oeb=1, sob=1, si=0, tx_ready=0, busy=0, priority=read.
REQ-018 Reset mid-transfer SHALL discard the byte in flight and SHALL NOT emit a partial strobe after the reset edge.

Configuration
REQ-019 With SLAVE_FIFO_SYNC_EN defined, fifo_slave_dor and fifo_host_dir SHALL pass through 2-flop synchronizers (reset to 0), adding 2 clocks of eligibility latency.
REQ-020 Without SLAVE_FIFO_SYNC_EN, the flags SHALL be used directly, combinationally.

Verification (default parameters, no sync macro)
REQ-021 dor=1, rx_ready=1, sd_in=0xA5 -> oeb low 3 clocks, sob low for clocks 2-3 of that window, rx_data=0xA5 with rx_valid one cycle after capture, IDLE after 5 clocks.
REQ-022 dir=1, tx_valid=1, tx_data=0x3C -> tx_ready pulses 1 cycle, sd_out=0x3C with sd_oe=1 for 5 clocks, si high exactly 2 clocks, wnr=1 only while sd_oe=1.
REQ-023 dor=1, dir=1 and tx_valid=1 held for 4 transfers -> order read, write, read, write; no cycle has sd_oe=1 while oeb=0.
REQ-024 rx_ready=0 after one read with dor still 1 -> no further oeb/sob activity and rx_data stable until rx_ready=1.
REQ-025 RESET asserted during WR_SI -> si=0, sd_oe=0 and FSM=IDLE on the next edge, with no extra strobe.
REQ-026 SLAVE_FIFO_SYNC_EN defined, dor rising -> oeb falls 2 clocks later than in the unsynchronized build.

Source files
------------

// File: rtl/slave_fifo_ctrl.sv
// Slave-side FIFO controller: arbitrates between reading a byte from the
// host->slave FIFO and writing a byte into the slave->host FIFO, sequencing
// output-enable, data settle, shift strobe and recovery phases.
// Optional build macro: SLAVE_FIFO_SYNC_EN adds 2-flop synchronizers on the
// FIFO ready flags. SETTLE_CYC, PULSE_CYC and RECOV_CYC must each be >= 1.
module slave_fifo_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int PULSE_CYC  = 2,
    parameter int RECOV_CYC  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       fifo_slave_dor,
    input  logic       fifo_host_dir,
    input  logic [7:0] sd_in,
    output logic [7:0] sd_out,
    output logic       sd_oe,
    output logic       slave_fifo_wnr,
    output logic       slave_fifo_oeb,
    output logic       slave_fifo_sob,
    output logic       slave_fifo_si,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int MAX_SP = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int MAX_P  = (MAX_SP > RECOV_CYC) ? MAX_SP : RECOV_CYC;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] RECOV_LAST  = CW'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_OE  = 3'd1,
        RD_SO  = 3'd2,
        WR_SET = 3'd3,
        WR_SI  = 3'd4,
        RECOV  = 3'd5
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic          prio_wr_r;
    logic          dor_s, dir_s;
    logic          rd_elig_s, wr_elig_s;
    logic          grant_rd_s, grant_wr_s;
    logic          capture_s;
    logic          oeb_r, sob_r, si_r, sd_oe_r, wnr_r, busy_r;
    logic          rx_valid_r;
    logic [7:0]    rx_data_r, sd_out_r;

`ifdef SLAVE_FIFO_SYNC_EN
    logic [1:0] dor_sync_r, dir_sync_r;

    // Two-flop synchronizers bringing the asynchronous FIFO flags into CLK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dor_sync_r <= 2'b00;
            dir_sync_r <= 2'b00;
        end else begin
            dor_sync_r <= {dor_sync_r[0], fifo_slave_dor};
            dir_sync_r <= {dir_sync_r[0], fifo_host_dir};
        end
    end

    assign dor_s = dor_sync_r[1];
    assign dir_s = dir_sync_r[1];
`else
    assign dor_s = fifo_slave_dor;
    assign dir_s = fifo_host_dir;
`endif

    // A read needs a free rx slot; a slot being consumed this cycle counts as free.
    assign rd_elig_s = dor_s & (~rx_valid_r | rx_ready);
    assign wr_elig_s = dir_s & tx_valid;
    assign capture_s = (state_r == RD_OE) && (cnt_r == SETTLE_LAST);

    // Arbitration in IDLE: alternate on contention, lone request always wins.
    always_comb begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
        if ((state_r == IDLE) && !RESET) begin
            if (rd_elig_s && wr_elig_s) begin
                if (prio_wr_r) begin
                    grant_wr_s = 1'b1;
                end else begin
                    grant_rd_s = 1'b1;
                end
            end else if (rd_elig_s) begin
                grant_rd_s = 1'b1;
            end else if (wr_elig_s) begin
                grant_wr_s = 1'b1;
            end else begin
                grant_rd_s = 1'b0;
            end
        end else begin
            grant_wr_s = 1'b0;
        end
    end

    // Next-state and phase counter: each phase ends when its counter hits last.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r + CW'(1);
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (grant_rd_s) begin
                    state_nx_s = RD_OE;
                end else if (grant_wr_s) begin
                    state_nx_s = WR_SET;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD_OE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nx_s = RD_SO;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = RD_OE;
                end
            end
            RD_SO: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nx_s = RECOV;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = RD_SO;
                end
            end
            WR_SET: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nx_s = WR_SI;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = WR_SET;
                end
            end
            WR_SI: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nx_s = RECOV;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = WR_SI;
                end
            end
            RECOV: begin
                if (cnt_r == RECOV_LAST) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = RECOV;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State register plus bus controls registered from the next state, so the
    // pins change on the same edge as the state and never glitch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            prio_wr_r <= 1'b0;
            oeb_r     <= 1'b1;
            sob_r     <= 1'b1;
            si_r      <= 1'b0;
            sd_oe_r   <= 1'b0;
            wnr_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (grant_rd_s) begin
                prio_wr_r <= 1'b1;
            end else if (grant_wr_s) begin
                prio_wr_r <= 1'b0;
            end else begin
                prio_wr_r <= prio_wr_r;
            end
            oeb_r   <= ~((state_nx_s == RD_OE) || (state_nx_s == RD_SO));
            sob_r   <= ~(state_nx_s == RD_SO);
            si_r    <= (state_nx_s == WR_SI);
            // The drive stays on through the write's RECOV and drops only in IDLE.
            sd_oe_r <= (state_nx_s == WR_SET) || (sd_oe_r && (state_nx_s != IDLE));
            wnr_r   <= (state_nx_s == WR_SET) || (wnr_r && (state_nx_s != IDLE));
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Data path: latch the tx byte on grant, capture sd_in at end of RD_OE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sd_out_r   <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            if (grant_wr_s) begin
                sd_out_r <= tx_data;
            end else begin
                sd_out_r <= sd_out_r;
            end
            if (capture_s) begin
                rx_data_r  <= sd_in;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign sd_out         = sd_out_r;
    assign sd_oe          = sd_oe_r;
    assign slave_fifo_wnr = wnr_r;
    assign slave_fifo_oeb = oeb_r;
    assign slave_fifo_sob = sob_r;
    assign slave_fifo_si  = si_r;
    assign rx_data        = rx_data_r;
    assign rx_valid       = rx_valid_r;
    assign tx_ready       = grant_wr_s;
    assign busy           = busy_r;

endmodule
